// File: rtl/change_dispenser_if.sv
// Handshake bundle between the change dispenser and its controller/hopper side.
interface change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       empty_25;
  logic       empty_10;
  logic       empty_5;
  logic       coin_ack;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] remain;
  logic [5:0] coin_cnt;

  modport master (
    output start, amount, empty_25, empty_10, empty_5, coin_ack,
    input  coin_req, coin_sel, busy, done, err, remain, coin_cnt
  );

  modport slave (
    input  start, amount, empty_25, empty_10, empty_5, coin_ack,
    output coin_req, coin_sel, busy, done, err, remain, coin_cnt
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout controller: pays the owed amount in 25/10/5c coins one
// hopper handshake at a time, skipping empty tubes and timing out a stuck hopper.
module change_dispenser (
  input  logic              clk,
  input  logic              rst_n,
  change_dispenser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SELECT, REQ, DONE} state_t;

  state_t     state;
  logic [7:0] tmo;
  logic [7:0] coin_val;
  logic [7:0] rem_next;

  always_comb begin
    coin_val = 8'd5;
    case (bus.coin_sel)
      2'd0:    coin_val = 8'd25;
      2'd1:    coin_val = 8'd10;
      default: coin_val = 8'd5;
    endcase
  end

  // SELECT only picks a coin no larger than remain, so this cannot wrap.
  assign rem_next = bus.remain - coin_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmo          <= 8'd0;
      bus.coin_req <= 1'b0;
      bus.coin_sel <= 2'd0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.remain   <= 8'd0;
      bus.coin_cnt <= 6'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.remain   <= bus.amount;
            bus.coin_cnt <= 6'd0;
            bus.busy     <= 1'b1;
            if (bus.amount % 8'd5 != 8'd0) begin
              bus.err <= 1'b1;
              state   <= DONE;
            end else if (bus.amount == 8'd0) begin
              bus.err <= 1'b0;
              state   <= DONE;
            end else begin
              bus.err <= 1'b0;
              state   <= SELECT;
            end
          end
        end
        SELECT: begin
          tmo <= 8'd0;
          if (!bus.empty_25 && bus.remain >= 8'd25) begin
            bus.coin_sel <= 2'd0;
            bus.coin_req <= 1'b1;
            state        <= REQ;
          end else if (!bus.empty_10 && bus.remain >= 8'd10) begin
            bus.coin_sel <= 2'd1;
            bus.coin_req <= 1'b1;
            state        <= REQ;
          end else if (!bus.empty_5 && bus.remain >= 8'd5) begin
            bus.coin_sel <= 2'd2;
            bus.coin_req <= 1'b1;
            state        <= REQ;
          end else begin
            bus.err <= 1'b1;
            state   <= DONE;
          end
        end
        REQ: begin
          if (bus.coin_ack) begin
            bus.remain   <= rem_next;
            bus.coin_cnt <= bus.coin_cnt + 6'd1;
            bus.coin_req <= 1'b0;
            state        <= (rem_next != 8'd0) ? SELECT : DONE;
          end else if (tmo == 8'hFF) begin
            // 256th silent cycle: give up on this hopper.
            bus.err      <= 1'b1;
            bus.coin_req <= 1'b0;
            state        <= DONE;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout model plus literal timing/result checks.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  change_dispenser_if bus();

  change_dispenser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passes = 0;

  int exp_coins[$];
  int m_rem, m_cnt, m_err;
  bit chk_en = 1'b0;
  bit ack_on = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int coin_value(input logic [1:0] sel);
    case (sel)
      2'd0:    return 25;
      2'd1:    return 10;
      2'd2:    return 5;
      default: return 0;
    endcase
  endfunction

  // Expected outcome of a payout from the owed amount and static tube state.
  task automatic plan(input int amt, input bit e25, input bit e10, input bit e5, input bit acks);
    int r, d;
    exp_coins.delete();
    r = amt;
    m_err = 0;
    if (amt % 5 != 0) m_err = 1;
    else begin
      while (r != 0) begin
        if (!e25 && r >= 25)      d = 25;
        else if (!e10 && r >= 10) d = 10;
        else if (!e5 && r >= 5)   d = 5;
        else                      d = 0;
        if (d == 0) begin m_err = 1; break; end
        exp_coins.push_back(d);
        if (!acks) begin m_err = 1; break; end
        r -= d;
      end
    end
    m_rem = r;
    m_cnt = acks ? exp_coins.size() : 0;
  endtask

  // Hopper: acknowledges every request on its first cycle when enabled.
  initial begin
    bus.coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.coin_ack = ack_on && bus.coin_req;
    end
  end

  // Compare process: coin choice on every new request, results on every done pulse.
  initial begin
    logic prev_req, prev_done;
    prev_req = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        if (bus.coin_req && !prev_req) begin
          if (exp_coins.size() == 0) check("spurious_coin_req", 1, 0);
          else check("coin_sel", coin_value(bus.coin_sel), exp_coins.pop_front());
        end
        if (bus.done) begin
          check("done_err", bus.err, m_err);
          check("done_remain", bus.remain, m_rem);
          check("done_coin_cnt", bus.coin_cnt, m_cnt);
          check("done_busy", bus.busy, 0);
          check("done_coins_left", exp_coins.size(), 0);
          check("done_single_cycle", prev_done, 0);
        end
      end
      prev_req = rst_n ? bus.coin_req : 1'b0;
      prev_done = rst_n ? bus.done : 1'b0;
    end
  end

  task automatic run(input int amt, input bit e25, input bit e10, input bit e5,
                     input bit acks, input bit poke,
                     output int lat_req, output int lat_done, output int req_cyc);
    @(negedge clk);
    bus.empty_25 = e25;
    bus.empty_10 = e10;
    bus.empty_5  = e5;
    ack_on = acks;
    plan(amt, e25, e10, e5, acks);
    chk_en = 1'b1;
    bus.amount = 8'(amt);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat_req = -1;
    lat_done = -1;
    req_cyc = 0;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      bus.start = poke && (k == 3);
      if (poke && k == 3) bus.amount = 8'd5;
      if (bus.coin_req) begin
        req_cyc++;
        if (lat_req < 0) lat_req = k;
      end
      if (bus.done) begin lat_done = k; break; end
    end
    bus.start = 1'b0;
    if (lat_done < 0) check("done_seen", 0, 1);
  endtask

  initial begin
    int lr, ld, rc, nreq, highs;
    logic pr;
    bus.start = 1'b0;
    bus.amount = 8'd0;
    bus.empty_25 = 1'b0;
    bus.empty_10 = 1'b0;
    bus.empty_5 = 1'b0;
    #12;
    check("rst_coin_req", bus.coin_req, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_remain", bus.remain, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 40c, all tubes full: 25,10,5 with two-cycle request spacing.
    run(40, 0, 0, 0, 1, 0, lr, ld, rc);
    check("t40_first_req_lat", lr, 2);
    check("t40_done_lat", ld, 8);
    check("t40_req_cycles", rc, 3);
    check("t40_cnt", bus.coin_cnt, 3);
    check("t40_remain", bus.remain, 0);

    // 30c without quarters: three dimes.
    run(30, 1, 0, 0, 1, 0, lr, ld, rc);
    check("t30_cnt", bus.coin_cnt, 3);
    check("t30_err", bus.err, 0);

    // 7c is not payable: early error, no coins.
    run(7, 0, 0, 0, 1, 0, lr, ld, rc);
    check("t7_done_lat", ld, 2);
    check("t7_req_cycles", rc, 0);
    repeat (5) @(negedge clk);
    check("t7_err_held", bus.err, 1);
    check("t7_remain_held", bus.remain, 7);

    // 15c with only quarters available: nothing fits.
    run(15, 0, 1, 1, 1, 0, lr, ld, rc);
    check("t15_done_lat", ld, 3);
    check("t15_remain", bus.remain, 15);
    check("t15_cnt", bus.coin_cnt, 0);
    check("t15_err", bus.err, 1);

    // 25c, hopper never answers: 256-cycle request then error.
    run(25, 0, 0, 0, 0, 0, lr, ld, rc);
    check("t25_req_cycles", rc, 256);
    check("t25_done_lat", ld, 259);
    check("t25_remain", bus.remain, 25);
    check("t25_err", bus.err, 1);

    // Zero owed: immediate clean completion.
    run(0, 0, 0, 0, 1, 0, lr, ld, rc);
    check("t0_done_lat", ld, 2);
    check("t0_err", bus.err, 0);

    // Start while busy must not disturb the running 40c payout.
    run(40, 0, 0, 0, 1, 1, lr, ld, rc);
    check("tpoke_done_lat", ld, 8);
    check("tpoke_cnt", bus.coin_cnt, 3);

    // Largest amount: ten quarters and a nickel.
    run(255, 0, 0, 0, 1, 0, lr, ld, rc);
    check("t255_cnt", bus.coin_cnt, 11);
    check("t255_remain", bus.remain, 0);

    // 20c without dimes: four nickels.
    run(20, 0, 1, 0, 1, 0, lr, ld, rc);
    check("t20_cnt", bus.coin_cnt, 4);

    // 50c, reset asserted during the second request.
    @(negedge clk);
    bus.empty_25 = 1'b0;
    bus.empty_10 = 1'b0;
    bus.empty_5 = 1'b0;
    ack_on = 1'b1;
    plan(50, 0, 0, 0, 1);
    chk_en = 1'b1;
    bus.amount = 8'd50;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    nreq = 0;
    pr = 1'b0;
    for (int k = 0; k < 100 && nreq < 2; k++) begin
      @(negedge clk);
      if (bus.coin_req && !pr) nreq++;
      pr = bus.coin_req;
    end
    check("trst_second_req", nreq, 2);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("trst_coin_req", bus.coin_req, 0);
    check("trst_coin_sel", bus.coin_sel, 0);
    check("trst_busy", bus.busy, 0);
    check("trst_done", bus.done, 0);
    check("trst_err", bus.err, 0);
    check("trst_remain", bus.remain, 0);
    check("trst_coin_cnt", bus.coin_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.coin_req || bus.busy) highs++;
    end
    check("trst_idle_after_release", highs, 0);

    // Fresh payout after the abandoned one.
    run(10, 0, 0, 0, 1, 0, lr, ld, rc);
    check("tpost_cnt", bus.coin_cnt, 1);
    check("tpost_remain", bus.remain, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to pay out change; sampled only in IDLE.
REQ-005 amount  input  8  change owed in cents; sampled with start.
REQ-006 empty_25, empty_10, empty_5  input  1 each  hopper tube empty flags; 1 means the denomination is unavailable.
REQ-007 coin_ack  input  1  hopper confirms one coin ejected; meaningful only while coin_req=1.
REQ-008 coin_req  output  1  request hopper to eject one coin of coin_sel.
REQ-009 coin_sel  output  2  denomination: 00=25c, 01=10c, 10=5c, 11 unused.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  payout failure flag, valid with done, held until next accepted start.
REQ-013 remain  output  8  cents still owed.
REQ-014 coin_cnt  output  6  coins ejected in current payout.

Function
REQ-015 The block SHALL implement states IDLE, SELECT, REQ, DONE with all outputs registered.
REQ-016 IDLE + start=1: latch amount into remain, clear coin_cnt and err; go to DONE with err=1 if amount mod 5 != 0, DONE with err=0 if amount=0, else SELECT.
REQ-017 start while busy=1 SHALL be ignored without side effects.
REQ-018 SELECT: choose the largest d in {25,10,5} with d <= remain and empty_d=0, drive coin_sel, go to REQ; if no d qualifies, go to DONE with err=1 and remain unchanged.
REQ-019 Empty flags SHALL be sampled only in SELECT; changes during REQ do not alter coin_sel.
REQ-020 REQ: coin_req=1 and coin_sel stable; timeout counter (8-bit) cleared on entry.
REQ-021 REQ + coin_ack=1: remain -= value(coin_sel), coin_cnt += 1, coin_req low next cycle; go to SELECT if new remain != 0, else DONE with err=0.
REQ-022 REQ with no coin_ack for 256 consecutive cycles: go to DONE with err=1, coin_req low, remain and coin_cnt unchanged.
REQ-023 remain SHALL never underflow; value(coin_sel) <= remain is guaranteed by SELECT.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; remain, coin_cnt, err hold until next accepted start.
REQ-025 Latency: start at edge N -> SELECT at N+1 -> coin_req=1 from edge N+2; ack at edge M -> next coin_req=1 from edge M+2.
REQ-026 coin_ack outside REQ SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, coin_req=0, coin_sel=00, busy=0, done=0, err=0, remain=0, coin_cnt=0, timeout=0, regardless of state.
REQ-028 Reset mid-payout SHALL abandon the payout; no coin_req after release until a new start.

Verification
REQ-029 amount=40, no tubes empty, ack 1 cycle after each req -> coins 25,10,5; done with err=0, remain=0, coin_cnt=3.
REQ-030 amount=30, empty_25=1 -> coins 10,10,10; err=0, coin_cnt=3.
REQ-031 amount=7 -> done 2 cycles after start, err=1, remain=7, coin_req never asserted.
REQ-032 amount=15, empty_10=1 and empty_5=1 -> no coin, done with err=1, remain=15, coin_cnt=0.
REQ-033 amount=25, coin_ack held low -> coin_req high 256 cycles, then done with err=1, remain=25.
REQ-034 amount=50, rst_n pulsed low during second REQ -> all outputs zero at once, IDLE after release, no coin_req without new start.
